// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Supports a bounded bus lock for read-modify-write sequences.
module mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0,
    parameter int LOCK_MAX   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // state | meaning
    // IDLE  | no owner, arbitrate every cycle
    // OWN0  | requester 0 holds the bus lock
    // OWN1  | requester 1 holds the bus lock
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);
    localparam logic       FIXED      = (FIXED_PRIO != 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic              w_prio_nxt;
    logic [7:0]        r_lock_cnt;
    logic [7:0]        w_cnt_nxt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_arb;
    logic              w_prio_eff;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_lock_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_rvalid0  <= w_gnt0 & ~we0;
            r_rvalid1  <= w_gnt1 & ~we1;
            if (r_rvalid0) r_rdata0 <= mem_data_out;
            if (r_rvalid1) r_rdata1 <= mem_data_out;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_lock_cnt;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_arb       = 1'b0;
        w_prio_eff  = r_prio;
        case (r_state)
            IDLE: w_arb = 1'b1;
            OWN0: begin
                // Forced release hands the tie-break to the other requester.
                if (r_lock_cnt >= LOCK_MAX_C) begin
                    w_arb      = 1'b1;
                    w_prio_eff = 1'b1;
                    w_prio_nxt = 1'b1;
                end else if (req0) begin
                    w_gnt0 = 1'b1;
                    if (lock0) begin
                        w_cnt_nxt = r_lock_cnt + 8'd1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            OWN1: begin
                if (r_lock_cnt >= LOCK_MAX_C) begin
                    w_arb      = 1'b1;
                    w_prio_eff = 1'b0;
                    w_prio_nxt = 1'b0;
                end else if (req1) begin
                    w_gnt1 = 1'b1;
                    if (lock1) begin
                        w_cnt_nxt = r_lock_cnt + 8'd1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_arb) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            if (req0 && (!req1 || FIXED || !w_prio_eff)) begin
                w_gnt0 = 1'b1;
            end else if (req1) begin
                w_gnt1 = 1'b1;
            end
            if (req0 && req1) w_prio_nxt = w_gnt0;
            if (w_gnt0 && lock0) begin
                w_state_nxt = OWN0;
                w_cnt_nxt   = 8'd1;
            end
            if (w_gnt1 && lock1) begin
                w_state_nxt = OWN1;
                w_cnt_nxt   = 8'd1;
            end
        end

        if (rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign gnt0         = w_gnt0;
    assign gnt1         = w_gnt1;
    assign mem_write_en = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign mem_read_en  = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);
    assign mem_add      = w_gnt0 ? addr0 : (w_gnt1 ? addr1 : '0);
    assign mem_data_in  = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);

    // A read in flight when reset arrives must not surface, and memory X never leaks out.
    assign rvalid0 = r_rvalid0 & ~rst;
    assign rvalid1 = r_rvalid1 & ~rst;
    assign rdata0  = rst ? '0 : (r_rvalid0 ? mem_data_out : r_rdata0);
    assign rdata1  = rst ? '0 : (r_rvalid1 ? mem_data_out : r_rdata1);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus hand-written lock/reset sequences,
// with a read-data scoreboard against a shadow copy of the memory.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       mem_init;

    logic       a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mwe, a_mre;
    logic [7:0] a_rdata0, a_rdata1, a_madd, a_mdin, a_mdout;
    logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mwe, b_mre;
    logic [7:0] b_rdata0, b_rdata1, b_madd, b_mdin, b_mdout;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] shadow [256];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] hold0 = 8'h00;
    logic [7:0] hold1 = 8'h00;

    typedef struct {
        logic       rst, r0, r1, w0, w1, l0, l1;
        logic [7:0] a0, a1, d0, d1;
        logic       g0, g1;
        logic       cb, bg0, bg1;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0), .LOCK_MAX(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
        .rdata0(a_rdata0), .rdata1(a_rdata1),
        .mem_write_en(a_mwe), .mem_read_en(a_mre), .mem_add(a_madd),
        .mem_data_in(a_mdin), .mem_data_out(a_mdout)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1), .LOCK_MAX(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_write_en(b_mwe), .mem_read_en(b_mre), .mem_add(b_madd),
        .mem_data_in(b_mdin), .mem_data_out(b_mdout)
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 16) return 8'hA5;
        return 8'(i * 7 + 3);
    endfunction

    // Behavioural 256x8 synchronous memories; data_out is X unless read the cycle before.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(i);
        end else begin
            if (a_mwe) mem_a[a_madd] <= a_mdin;
            if (a_mre) a_mdout <= mem_a[a_madd];
            else       a_mdout <= 8'hxx;
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_val(i);
        end else begin
            if (b_mwe) mem_b[b_madd] <= b_mdin;
            if (b_mre) b_mdout <= mem_b[b_madd];
            else       b_mdout <= 8'hxx;
        end
    end

    function automatic vec_t mk(input int rs, input int r0, input int r1, input int w0,
                                input int w1, input int l0, input int l1, input int a0,
                                input int a1, input int d0, input int d1, input int g0,
                                input int g1);
        vec_t v;
        v.rst = rs[0]; v.r0 = r0[0]; v.r1 = r1[0]; v.w0 = w0[0]; v.w1 = w1[0];
        v.l0 = l0[0]; v.l1 = l1[0];
        v.a0 = 8'(a0); v.a1 = 8'(a1); v.d0 = 8'(d0); v.d1 = 8'(d1);
        v.g0 = g0[0]; v.g1 = g1[0];
        v.cb = 1'b0; v.bg0 = 1'b0; v.bg1 = 1'b0;
        return v;
    endfunction

    function automatic vec_t with_b(input vec_t vin, input int bg0, input int bg1);
        vec_t v;
        v = vin;
        v.cb = 1'b1; v.bg0 = bg0[0]; v.bg1 = bg1[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic       e_rv0, e_rv1;
        logic [7:0] e_d0, e_d1;
        rst = v.rst; req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
        lock0 = v.l0; lock1 = v.l1; addr0 = v.a0; addr1 = v.a1;
        wdata0 = v.d0; wdata1 = v.d1;
        @(negedge clk);
        e_rv0 = (q0.size() > 0) && !v.rst;
        e_rv1 = (q1.size() > 0) && !v.rst;
        chk("rvalid0", {7'd0, a_rvalid0}, {7'd0, e_rv0});
        chk("rvalid1", {7'd0, a_rvalid1}, {7'd0, e_rv1});
        if (e_rv0) begin e_d0 = q0.pop_front(); hold0 = e_d0; end
        else e_d0 = v.rst ? 8'h00 : hold0;
        if (e_rv1) begin e_d1 = q1.pop_front(); hold1 = e_d1; end
        else e_d1 = v.rst ? 8'h00 : hold1;
        chk("rdata0", a_rdata0, e_d0);
        chk("rdata1", a_rdata1, e_d1);
        if (v.rst) begin
            q0.delete(); q1.delete();
            hold0 = 8'h00; hold1 = 8'h00;
        end
        chk("gnt0", {7'd0, a_gnt0}, {7'd0, v.g0});
        chk("gnt1", {7'd0, a_gnt1}, {7'd0, v.g1});
        chk("mem_write_en", {7'd0, a_mwe}, {7'd0, (v.g0 & v.w0) | (v.g1 & v.w1)});
        chk("mem_read_en", {7'd0, a_mre}, {7'd0, (v.g0 & ~v.w0) | (v.g1 & ~v.w1)});
        chk("mem_add", a_madd, v.g0 ? v.a0 : (v.g1 ? v.a1 : 8'h00));
        chk("mem_data_in", a_mdin, v.g0 ? v.d0 : (v.g1 ? v.d1 : 8'h00));
        if (v.cb) begin
            chk("fixed_gnt0", {7'd0, b_gnt0}, {7'd0, v.bg0});
            chk("fixed_gnt1", {7'd0, b_gnt1}, {7'd0, v.bg1});
        end
        if (v.g0 && !v.w0) q0.push_back(shadow[v.a0]);
        if (v.g0 && v.w0)  shadow[v.a0] = v.d0;
        if (v.g1 && !v.w1) q1.push_back(shadow[v.a1]);
        if (v.g1 && v.w1)  shadow[v.a1] = v.d1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0; addr0 = 8'h00; addr1 = 8'h00;
        wdata0 = 8'h00; wdata1 = 8'h00; mem_init = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        @(posedge clk);
        #1;
        mem_init = 1'b0;

        //                rst r0 r1 w0 w1 l0 l1 a0    a1    d0    d1    g0 g1
        tbl.push_back(mk(1,  1, 1, 0, 0, 0, 0, 'h10, 'h11, 0,    0,    0, 0));
        tbl.push_back(mk(1,  0, 0, 0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
        // single read of the preloaded 0xA5, then hold
        tbl.push_back(mk(0,  1, 0, 0, 0, 0, 0, 'h10, 0,    0,    0,    1, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
        // round-robin contention
        tbl.push_back(mk(0,  1, 1, 0, 0, 0, 0, 'h11, 'h12, 0,    0,    1, 0));
        tbl.push_back(mk(0,  1, 1, 0, 0, 0, 0, 'h11, 'h12, 0,    0,    0, 1));
        tbl.push_back(mk(0,  1, 1, 0, 0, 0, 0, 'h11, 'h12, 0,    0,    1, 0));
        tbl.push_back(mk(0,  1, 1, 0, 0, 0, 0, 'h11, 'h12, 0,    0,    0, 1));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
        // write then read-after-write across requesters
        tbl.push_back(mk(0,  0, 1, 0, 1, 0, 0, 0,    'h20, 0,    'h3C, 0, 1));
        tbl.push_back(mk(0,  1, 0, 0, 0, 0, 0, 'h20, 0,    0,    0,    1, 0));
        tbl.push_back(mk(0,  1, 0, 1, 0, 0, 0, 'h21, 0,    'h5E, 0,    1, 0));
        tbl.push_back(mk(0,  0, 1, 0, 0, 0, 0, 0,    'h21, 0,    0,    0, 1));
        tbl.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
        foreach (tbl[i]) apply(tbl[i]);

        // bounded lock with requester 1 pending: four grants to 0, forced release to 1
        for (int i = 0; i < 4; i++)
            apply(mk(0, 1, 1, 0, 0, 1, 0, 'h30, 'h31, 0, 0, 1, 0));
        apply(mk(0, 1, 1, 0, 0, 1, 0, 'h30, 'h31, 0, 0, 0, 1));
        apply(mk(0, 1, 0, 0, 0, 1, 0, 'h30, 0,    0, 0, 1, 0));
        apply(mk(0, 1, 1, 0, 0, 0, 0, 'h32, 'h31, 0, 0, 1, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0,    'h31, 0, 0, 0, 1));
        // lock released by dropping req: the release cycle grants nobody
        apply(mk(0, 1, 0, 1, 0, 1, 0, 'h40, 0,    'h77, 0, 1, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0,    'h40, 0,    0, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0,    'h40, 0,    0, 0, 1));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,    0,    0,    0, 0, 0));

        // reset with a locked read in flight, then contention from a clean IDLE/prio=0
        apply(mk(0, 1, 1, 0, 0, 0, 0, 'h41, 'h42, 0, 0, 1, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 1, 0,    'h50, 0, 0, 0, 1));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0));
        apply(with_b(mk(0, 1, 1, 0, 0, 0, 0, 'h60, 'h61, 0, 0, 1, 0), 1, 0));
        apply(with_b(mk(0, 1, 1, 0, 0, 0, 0, 'h60, 'h61, 0, 0, 0, 1), 1, 0));
        apply(with_b(mk(0, 1, 1, 0, 0, 0, 0, 'h60, 'h61, 0, 0, 1, 0), 1, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        chk("reads_drained", 8'(q0.size() + q1.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
